alu_share_sequencer: RTL

//  Time-multiplexes the single combinational ALU between two requesters: port 0 (execute stage)
//  and port 1 (address/branch-target unit). Round-robin grant, operand capture, one ALU evaluation,

---
 rtl/alu_ops_pkg.sv | 32 +++
 rtl/alu_share_sequencer_if.sv | 65 ++++++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/alu_share_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// ALU op-code encodings and legality check, shared by the op translator, the ALU and the
// ALU sharing sequencer.
package alu_ops_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  function automatic logic is_legal_alu_op(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_AND, ALU_OR, ALU_XOR, ALU_SLTU, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_sequencer_if.sv
// Request/response channels of both ALU requesters plus the shared ALU drive and result.
// master = requesters/ALU side, slave = sequencer.
interface alu_share_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
);

  logic                              req0_valid;
  logic                              req0_ready;
  logic [alu_ops_pkg::ALU_OP_W-1:0]  req0_op;
  logic [XLEN-1:0]                   req0_a;
  logic [XLEN-1:0]                   req0_b;
  logic [TAG_W-1:0]                  req0_tag;

  logic                              req1_valid;
  logic                              req1_ready;
  logic [alu_ops_pkg::ALU_OP_W-1:0]  req1_op;
  logic [XLEN-1:0]                   req1_a;
  logic [XLEN-1:0]                   req1_b;
  logic [TAG_W-1:0]                  req1_tag;

  logic [alu_ops_pkg::ALU_OP_W-1:0]  alu_op;
  logic [XLEN-1:0]                   alu_a;
  logic [XLEN-1:0]                   alu_b;
  logic [XLEN-1:0]                   alu_result;

  logic                              rsp0_valid;
  logic                              rsp0_ready;
  logic [XLEN-1:0]                   rsp0_result;
  logic [TAG_W-1:0]                  rsp0_tag;
  logic                              rsp0_err;

  logic                              rsp1_valid;
  logic                              rsp1_ready;
  logic [XLEN-1:0]                   rsp1_result;
  logic [TAG_W-1:0]                  rsp1_tag;
  logic                              rsp1_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result,
    input  rsp0_valid, rsp0_result, rsp0_tag, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_tag, rsp1_err,
    output rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result,
    output rsp0_valid, rsp0_result, rsp0_tag, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_tag, rsp1_err,
    input  rsp1_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
// last_grant resets to 1 so port 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one combinational ALU between two requesters: round-robin grant, operand capture,
// one ALU evaluation, registered result returned on the winner's response channel.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a request; ready raised on the granted port only
// ST_EXEC | latched operands on the ALU, result/err captured this cycle
// ST_RESP | result held on the owner's response channel until taken
module alu_share_sequencer
  import alu_ops_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_share_sequencer_if.slave bus
);

  seq_state_t state, state_nxt;

  logic [1:0]          req_valid;
  logic [1:0]          grant;
  logic                accept;
  logic                owner_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [XLEN-1:0]     result_q;
  logic                err_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // ready depends only on valids, arbiter state and FSM state; never on response ready
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req0_ready = grant[0] & reset_n;
        bus.req1_ready = grant[1] & reset_n;
        accept         = |grant;
        if (accept) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp0_valid = ~owner_q;
        bus.rsp1_valid = owner_q;
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_q <= grant[1];
        op_q    <= grant[1] ? bus.req1_op  : bus.req0_op;
        a_q     <= grant[1] ? bus.req1_a   : bus.req0_a;
        b_q     <= grant[1] ? bus.req1_b   : bus.req0_b;
        tag_q   <= grant[1] ? bus.req1_tag : bus.req0_tag;
      end
      if (state == ST_EXEC) begin
        if (is_legal_alu_op(op_q)) begin
          result_q <= bus.alu_result;
          err_q    <= 1'b0;
        end else begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      end
    end
  end

  // ALU inputs come straight from the operand registers, so they hold when idle
  assign bus.alu_op = op_q;
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;

  assign bus.rsp0_result = owner_q ? '0   : result_q;
  assign bus.rsp0_tag    = owner_q ? '0   : tag_q;
  assign bus.rsp0_err    = ~owner_q & err_q;
  assign bus.rsp1_result = owner_q ? result_q : '0;
  assign bus.rsp1_tag    = owner_q ? tag_q    : '0;
  assign bus.rsp1_err    = owner_q & err_q;

endmodule
